// File: rtl/dual_input_debouncer_pkg.sv
// rtl/dual_input_debouncer_pkg.sv - shared constants and width helper for the debouncer
package dual_input_debouncer_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/dual_input_debouncer_if.sv
// rtl/dual_input_debouncer_if.sv - raw inputs and conditioned outputs of the debouncer
interface dual_input_debouncer_if;
    logic a_raw;
    logic b_raw;
    logic a_clean;
    logic b_clean;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;
    logic settled;

    modport master (
        output a_raw, b_raw,
        input  a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, settled
    );

    modport slave (
        input  a_raw, b_raw,
        output a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, settled
    );
endinterface

// File: rtl/dual_input_debouncer_channel.sv
// rtl/dual_input_debouncer_channel.sv - one synchronizer + counter + clean level channel
module debounce_channel
    import dual_input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic cnt_zero
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            // Any return to the clean level restarts the qualification window.
            if (sync2 == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                clean <= sync2;
                rise  <= sync2;
                fall  <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/dual_input_debouncer.sv
// rtl/dual_input_debouncer.sv - two independent debounce channels plus a settled flag
module dual_input_debouncer
    import dual_input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input logic                  clk,
    input logic                  rst,
    dual_input_debouncer_if.slave bus
);

    logic a_cnt_zero;
    logic b_cnt_zero;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_a (
        .clk      (clk),
        .rst      (rst),
        .raw      (bus.a_raw),
        .clean    (bus.a_clean),
        .rise     (bus.a_rise),
        .fall     (bus.a_fall),
        .cnt_zero (a_cnt_zero)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_b (
        .clk      (clk),
        .rst      (rst),
        .raw      (bus.b_raw),
        .clean    (bus.b_clean),
        .rise     (bus.b_rise),
        .fall     (bus.b_fall),
        .cnt_zero (b_cnt_zero)
    );

    // Derived only from counter state, never from the raw inputs.
    assign bus.settled = a_cnt_zero & b_cnt_zero;

endmodule

// File: tb/tb_dual_input_debouncer.sv
// tb/tb_dual_input_debouncer.sv - vector and scoreboard bench for dual_input_debouncer
module tb_dual_input_debouncer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dual_input_debouncer_if bus();

    dual_input_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Output vector order: {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, settled}
    typedef struct packed {
        logic       rst;
        logic       a;
        logic       b;
        logic [6:0] exp;
    } vec_t;

    logic [6:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    localparam logic [6:0] IDLE0 = 7'b0000001;
    localparam logic [6:0] BUSY0 = 7'b0000000;

    task automatic step(input logic r, input logic a, input logic b,
                        input logic [6:0] exp, input string name);
        logic [6:0] got;
        logic [6:0] want;
        exp_q.push_back(exp);
        rst = r;
        bus.a_raw = a;
        bus.b_raw = b;
        @(posedge clk);
        #1;
        got = {bus.a_clean, bus.b_clean, bus.a_rise, bus.a_fall,
               bus.b_rise, bus.b_fall, bus.settled};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b expected %b (ac bc ar af br bf st)", name, got, want);
        end
    endtask

    task automatic hold(input int n, input logic a, input logic b,
                        input logic [6:0] exp, input string name);
        for (int i = 0; i < n; i++) step(1'b0, a, b, exp, name);
    endtask

    vec_t vecs[24];

    initial begin
        rst = 1'b1;
        bus.a_raw = 1'b0;
        bus.b_raw = 1'b0;

        // Reset with both raws high, release, both rise on edge 6; B falls; then A falls with B rising.
        for (int i = 0; i < 3; i++) vecs[i] = '{1'b1, 1'b1, 1'b1, 7'b0000001};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 7'b0000001};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 7'b0000001};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 7'b0000000};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 7'b0000000};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 7'b0000000};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 7'b1110101};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 7'b1100001};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 7'b1100001};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 7'b1100001};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 7'b1100000};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 7'b1100000};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 7'b1100000};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 7'b1000011};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 7'b1000001};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 7'b1000001};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 7'b1000001};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 7'b1000000};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 7'b1000000};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 7'b1000000};
        vecs[22] = '{1'b0, 1'b0, 1'b1, 7'b0101101};
        vecs[23] = '{1'b0, 1'b0, 1'b1, 7'b0100001};

        for (int i = 0; i < 24; i++)
            step(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // Return to all-zero state.
        step(1'b1, 1'b0, 1'b0, IDLE0, "rst_to_zero");
        hold(3, 1'b0, 1'b0, IDLE0, "idle");

        // Clean step on A: rise at k+5, B untouched.
        hold(2, 1'b1, 1'b0, IDLE0, "step_pre");
        hold(3, 1'b1, 1'b0, BUSY0, "step_cnt");
        step(1'b0, 1'b1, 1'b0, 7'b1010001, "step_rise");
        step(1'b0, 1'b1, 1'b0, 7'b1000001, "step_hold");
        hold(2, 1'b0, 1'b0, 7'b1000001, "stepdn_pre");
        hold(3, 1'b0, 1'b0, 7'b1000000, "stepdn_cnt");
        step(1'b0, 1'b0, 1'b0, 7'b0001001, "stepdn_fall");
        hold(3, 1'b0, 1'b0, IDLE0, "stepdn_idle");

        // Glitch of 3 cycles is rejected and counter returns to zero.
        step(1'b0, 1'b1, 1'b0, IDLE0, "glitch_e0");
        step(1'b0, 1'b1, 1'b0, IDLE0, "glitch_e1");
        step(1'b0, 1'b1, 1'b0, BUSY0, "glitch_e2");
        step(1'b0, 1'b0, 1'b0, BUSY0, "glitch_e3");
        step(1'b0, 1'b0, 1'b0, BUSY0, "glitch_e4");
        hold(4, 1'b0, 1'b0, IDLE0, "glitch_after");

        // Pulse of exactly 4 cycles is accepted, then released 4 cycles later.
        step(1'b0, 1'b1, 1'b0, IDLE0, "thr_e0");
        step(1'b0, 1'b1, 1'b0, IDLE0, "thr_e1");
        step(1'b0, 1'b1, 1'b0, BUSY0, "thr_e2");
        step(1'b0, 1'b1, 1'b0, BUSY0, "thr_e3");
        step(1'b0, 1'b0, 1'b0, BUSY0, "thr_e4");
        step(1'b0, 1'b0, 1'b0, 7'b1010001, "thr_rise");
        hold(3, 1'b0, 1'b0, 7'b1000000, "thr_cnt");
        step(1'b0, 1'b0, 1'b0, 7'b0001001, "thr_fall");
        hold(3, 1'b0, 1'b0, IDLE0, "thr_idle");

        // Reset mid-count discards the pending rise; re-debounces after release.
        step(1'b0, 1'b1, 1'b0, IDLE0, "rmid_e0");
        step(1'b0, 1'b1, 1'b0, IDLE0, "rmid_e1");
        step(1'b0, 1'b1, 1'b0, BUSY0, "rmid_e2");
        step(1'b1, 1'b1, 1'b0, IDLE0, "rmid_rst");
        hold(2, 1'b1, 1'b0, IDLE0, "rmid_sync");
        hold(3, 1'b1, 1'b0, BUSY0, "rmid_cnt");
        step(1'b0, 1'b1, 1'b0, 7'b1010001, "rmid_rise");
        step(1'b0, 1'b1, 1'b0, 7'b1000001, "rmid_hold");

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
